// File: rtl/panel_pkg.sv
// panel_pkg: types and constants shared by the panel column-scan logic.
//   NUM_COLS_DEFAULT : default column count of the panel
//   COL_IDX_W        : width of a binary column index
//   sel_t            : column command issued by the shift-control FSM
package panel_pkg;

  localparam int NUM_COLS_DEFAULT = 24;
  localparam int COL_IDX_W        = $clog2(NUM_COLS_DEFAULT);

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_LOAD  = 2'd1,
    SEL_SHIFT = 2'd2,
    SEL_RSVD  = 2'd3
  } sel_t;

endpackage

// File: rtl/column_shifter_if.sv
// column_shifter_if: bundles the command inputs and the scan outputs of
// column_shifter.
//   master modport (shift FSM / row path side): drives en, sel, scroll_en;
//                  observes active_col, col_idx, col_blank, frame_start,
//                  scroll_pos, tick, err
//   slave modport  (column_shifter side): the mirror image
interface column_shifter_if import panel_pkg::*; #(
  parameter int NUM_COLS = NUM_COLS_DEFAULT
) ();

  localparam int IDX_W = $clog2(NUM_COLS);

  logic                en;
  sel_t                sel;
  logic                scroll_en;
  logic [NUM_COLS-1:0] active_col;
  logic [IDX_W-1:0]    col_idx;
  logic                col_blank;
  logic                frame_start;
  logic [IDX_W-1:0]    scroll_pos;
  logic                tick;
  logic                err;

  modport master (
    output en, sel, scroll_en,
    input  active_col, col_idx, col_blank, frame_start, scroll_pos, tick, err
  );

  modport slave (
    input  en, sel, scroll_en,
    output active_col, col_idx, col_blank, frame_start, scroll_pos, tick, err
  );

endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to one command-sample tick per column
// dwell period.
//   clk     : system clock
//   reset_n : synchronous active-low reset, clears the count
//   en      : count enable; the count is frozen while low
//   tick    : high during the cycle the count sits at TICK_DIV-1 with en high
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Combinational so the tick cycle is exactly the terminal-count cycle;
  // consumers register the effect of the command at the end of it.
  assign tick = en && (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/column_shifter.sv
// column_shifter: owns the one-hot active-column register of the panel scan.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   bus     : column_shifter_if slave port
//     en          in   scan enable (freezes the dwell prescaler when low)
//     sel         in   HOLD / LOAD / SHIFT / reserved, sampled on tick only
//     scroll_en   in   allows scroll_pos to advance on a frame start
//     active_col  out  one-hot active column, bit 0 = leftmost
//     col_idx     out  binary index of the active column
//     col_blank   out  high for BLANK_CYCLES clocks after each column change
//     frame_start out  one-cycle pulse when the scan returns to column 0
//     scroll_pos  out  per-frame scroll offset, 0..NUM_COLS-1
//     tick        out  command-sample strobe
//     err         out  sticky: reserved command seen or one-hot broken
module column_shifter import panel_pkg::*; #(
  parameter int NUM_COLS     = NUM_COLS_DEFAULT,
  parameter int TICK_DIV     = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  column_shifter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_COLS);
  localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_COLS - 1);
  localparam logic [BLK_W-1:0]    BLANK_LOAD = BLK_W'(BLANK_CYCLES);
  localparam logic [NUM_COLS-1:0] FIRST_COL  = NUM_COLS'(1);

  logic w_tick;
  logic w_load;
  logic w_shift;
  logic w_rsvd;
  logic w_wrap;
  logic w_frame;

  logic [NUM_COLS-1:0] r_active_col;
  logic [IDX_W-1:0]    r_col_idx;
  logic [IDX_W-1:0]    r_scroll_pos;
  logic [BLK_W-1:0]    r_blank_cnt;
  logic                r_frame_start;
  logic                r_err;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (bus.en),
    .tick   (w_tick)
  );

  assign w_load  = w_tick && (bus.sel == SEL_LOAD);
  assign w_shift = w_tick && (bus.sel == SEL_SHIFT);
  assign w_rsvd  = w_tick && (bus.sel == SEL_RSVD);
  // A shift out of the last column wraps to column 0 and starts a new frame.
  assign w_wrap  = w_shift && r_active_col[NUM_COLS-1];
  assign w_frame = w_load || w_wrap;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_active_col  <= FIRST_COL;
      r_col_idx     <= '0;
      r_scroll_pos  <= '0;
      r_blank_cnt   <= '0;
      r_frame_start <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_load) begin
        r_active_col <= FIRST_COL;
        r_col_idx    <= '0;
      end else if (w_shift) begin
        r_active_col <= {r_active_col[NUM_COLS-2:0], r_active_col[NUM_COLS-1]};
        r_col_idx    <= w_wrap ? '0 : r_col_idx + 1'b1;
      end

      // LOAD counts as a change even when column 0 is already active.
      if (w_load || w_shift) begin
        r_blank_cnt <= BLANK_LOAD;
      end else if (r_blank_cnt != '0) begin
        r_blank_cnt <= r_blank_cnt - 1'b1;
      end

      r_frame_start <= w_frame;

      // Lands on the same edge that raises frame_start.
      if (w_frame && bus.scroll_en) begin
        r_scroll_pos <= (r_scroll_pos == LAST_IDX) ? '0 : r_scroll_pos + 1'b1;
      end

      if (w_rsvd || !$onehot(r_active_col)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.active_col  = r_active_col;
  assign bus.col_idx     = r_col_idx;
  assign bus.col_blank   = (r_blank_cnt != '0);
  assign bus.frame_start = r_frame_start;
  assign bus.scroll_pos  = r_scroll_pos;
  assign bus.tick        = w_tick;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_column_shifter.sv
// tb_column_shifter: directed test of column_shifter with TICK_DIV = 4,
// BLANK_CYCLES = 2, NUM_COLS = 24.
module tb_column_shifter;
  import panel_pkg::*;

  localparam int NC = 24;
  localparam int TD = 4;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  column_shifter_if #(.NUM_COLS(NC)) bus ();

  column_shifter #(
    .NUM_COLS    (NC),
    .TICK_DIV    (TD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait until the current cycle is a tick cycle.
  task automatic wait_tick(input string tag);
    for (int i = 0; i < 3 * TD + 4; i++) begin
      if (bus.tick === 1'b1) return;
      step();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: tick timeout, got no tick, required one within %0d cycles", tag, 3 * TD + 4);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus.en = 1'b1; bus.sel = SEL_SHIFT; bus.scroll_en = 1'b0;
    step(); step(); step();
    n_cmp++; if (bus.active_col !== 24'h000001) begin n_bad++; $display("FAIL reset_col got %h required 000001", bus.active_col); end
    n_cmp++; if (bus.col_idx !== 5'd0) begin n_bad++; $display("FAIL reset_idx got %0d required 0", bus.col_idx); end
    n_cmp++; if (bus.tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b required 0", bus.tick); end
    n_cmp++; if ({bus.col_blank, bus.frame_start, bus.err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b required 000", {bus.col_blank, bus.frame_start, bus.err}); end
    n_cmp++; if (bus.scroll_pos !== 5'd0) begin n_bad++; $display("FAIL reset_scroll got %0d required 0", bus.scroll_pos); end
    reset_n = 1'b1; bus.sel = SEL_HOLD;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      n_cmp++;
      if (bus.tick !== (c == 4)) begin n_bad++; $display("FAIL first_tick cycle %0d got %b required %b", c, bus.tick, (c == 4)); end
    end
    $display("reset: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_shift_walk();
    logic [NC-1:0] exp_col;
    bus.sel = SEL_SHIFT;
    for (int k = 1; k <= NC; k++) begin
      exp_col = 24'h000001 << (k % NC);
      step();
      n_cmp++; if (bus.active_col !== exp_col) begin n_bad++; $display("FAIL walk_col k=%0d got %h required %h", k, bus.active_col, exp_col); end
      n_cmp++; if (bus.col_idx !== 5'(k % NC)) begin n_bad++; $display("FAIL walk_idx k=%0d got %0d required %0d", k, bus.col_idx, k % NC); end
      n_cmp++; if (bus.frame_start !== (k == NC)) begin n_bad++; $display("FAIL walk_frame k=%0d got %b required %b", k, bus.frame_start, (k == NC)); end
      n_cmp++; if (bus.col_blank !== 1'b1) begin n_bad++; $display("FAIL walk_blank1 k=%0d got %b required 1", k, bus.col_blank); end
      step();
      n_cmp++; if ({bus.col_blank, bus.frame_start} !== 2'b10) begin n_bad++; $display("FAIL walk_blank2 k=%0d got %b required 10", k, {bus.col_blank, bus.frame_start}); end
      step();
      n_cmp++; if (bus.col_blank !== 1'b0) begin n_bad++; $display("FAIL walk_blank3 k=%0d got %b required 0", k, bus.col_blank); end
      step();
      n_cmp++; if (bus.tick !== 1'b1) begin n_bad++; $display("FAIL walk_tick k=%0d got %b required 1", k, bus.tick); end
      n_cmp++; if (bus.scroll_pos !== 5'd0) begin n_bad++; $display("FAIL walk_scroll k=%0d got %0d required 0", k, bus.scroll_pos); end
      $display("shift_walk: step %0d col=%h idx=%0d", k, bus.active_col, bus.col_idx);
    end
  endtask

  task automatic test_load_mid_scan();
    bus.sel = SEL_SHIFT;
    for (int i = 0; i < 22; i++) begin
      step();
      wait_tick("load_pre");
    end
    n_cmp++; if (bus.active_col !== 24'h400000) begin n_bad++; $display("FAIL load_pre_col got %h required 400000", bus.active_col); end
    n_cmp++; if (bus.col_idx !== 5'd22) begin n_bad++; $display("FAIL load_pre_idx got %0d required 22", bus.col_idx); end
    bus.sel = SEL_LOAD;
    step();
    n_cmp++; if (bus.active_col !== 24'h000001) begin n_bad++; $display("FAIL load_col got %h required 000001", bus.active_col); end
    n_cmp++; if (bus.col_idx !== 5'd0) begin n_bad++; $display("FAIL load_idx got %0d required 0", bus.col_idx); end
    n_cmp++; if ({bus.frame_start, bus.col_blank} !== 2'b11) begin n_bad++; $display("FAIL load_flags got %b required 11", {bus.frame_start, bus.col_blank}); end
    n_cmp++; if (bus.scroll_pos !== 5'd0) begin n_bad++; $display("FAIL load_scroll got %0d required 0", bus.scroll_pos); end
    step();
    n_cmp++; if (bus.frame_start !== 1'b0) begin n_bad++; $display("FAIL load_frame_pulse got %b required 0", bus.frame_start); end
    $display("load_mid_scan: col=%h idx=%0d", bus.active_col, bus.col_idx);
    wait_tick("load_post");
  endtask

  task automatic test_enable_gating();
    bus.sel = SEL_SHIFT;
    step();                       // prescaler count 0, column 1 active
    step();                       // count 1
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if ({bus.tick, bus.active_col} !== {1'b0, 24'h000002}) begin n_bad++; $display("FAIL gate_hold i=%0d got tick=%b col=%h required tick=0 col=000002", i, bus.tick, bus.active_col); end
    end
    bus.en = 1'b1;
    // Held count was 1: ticks 0,0,1 over this cycle and the next two.
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      n_cmp++; if (bus.tick !== (c == 2)) begin n_bad++; $display("FAIL gate_resume c=%0d got %b required %b", c, bus.tick, (c == 2)); end
    end
    bus.sel = SEL_HOLD;
    step();
    n_cmp++; if ({bus.active_col, bus.col_blank} !== {24'h000002, 1'b0}) begin n_bad++; $display("FAIL gate_hold_cmd got col=%h blank=%b required col=000002 blank=0", bus.active_col, bus.col_blank); end
    $display("enable_gating: col=%h after resume", bus.active_col);
    wait_tick("gate_post");
  endtask

  task automatic test_scroll_wrap();
    bus.sel = SEL_LOAD; bus.scroll_en = 1'b1;
    for (int k = 1; k <= NC; k++) begin
      step();
      n_cmp++; if (bus.scroll_pos !== 5'(k % NC)) begin n_bad++; $display("FAIL scroll k=%0d got %0d required %0d", k, bus.scroll_pos, k % NC); end
      n_cmp++; if (bus.frame_start !== 1'b1) begin n_bad++; $display("FAIL scroll_frame k=%0d got %b required 1", k, bus.frame_start); end
      $display("scroll_wrap: load %0d scroll_pos=%0d", k, bus.scroll_pos);
      wait_tick("scroll");
    end
    bus.scroll_en = 1'b0;
  endtask

  task automatic test_error();
    bus.sel = SEL_LOAD; bus.scroll_en = 1'b1;
    step();
    n_cmp++; if (bus.scroll_pos !== 5'd1) begin n_bad++; $display("FAIL err_pre_scroll got %0d required 1", bus.scroll_pos); end
    bus.scroll_en = 1'b0;
    wait_tick("err_pre");
    bus.sel = SEL_RSVD;
    step();
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b required 1", bus.err); end
    n_cmp++; if ({bus.active_col, bus.col_blank, bus.frame_start} !== {24'h000001, 2'b00}) begin n_bad++; $display("FAIL err_hold got col=%h blank=%b frame=%b required col=000001 blank=0 frame=0", bus.active_col, bus.col_blank, bus.frame_start); end
    bus.sel = SEL_SHIFT;
    for (int k = 1; k <= 2; k++) begin
      wait_tick("err_shift");
      step();
      n_cmp++; if ({bus.err, bus.active_col} !== {1'b1, 24'h000001 << k}) begin n_bad++; $display("FAIL err_sticky k=%0d got err=%b col=%h required err=1 col=%h", k, bus.err, bus.active_col, 24'h000001 << k); end
    end
    reset_n = 1'b0;
    step();
    n_cmp++; if ({bus.err, bus.active_col, bus.col_idx, bus.scroll_pos} !== {1'b0, 24'h000001, 5'd0, 5'd0}) begin n_bad++; $display("FAIL err_reset got err=%b col=%h idx=%0d scroll=%0d required err=0 col=000001 idx=0 scroll=0", bus.err, bus.active_col, bus.col_idx, bus.scroll_pos); end
    reset_n = 1'b1;
    $display("error: err=%b after reset", bus.err);
  endtask

  initial begin
    test_reset();
    test_shift_walk();
    test_load_mid_scan();
    test_enable_gating();
    test_scroll_wrap();
    test_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/column_shifter.md
Name: column_shifter

Overview:
- Owns the one-hot active-column register that drives the 24-column panel scan.
- Consumes the 2-bit SEL command from the shift-control FSM, applied once per column dwell period.
- Produces active_col, which feeds back to the FSM, plus column index, blanking, frame-start and scroll position for the row-data path.
- Sits between the shift-control FSM (upstream) and the row/column panel drivers (downstream).

Parameters:
- NUM_COLS, 24, number of panel columns; width of active_col.
- TICK_DIV, 1000, clk cycles per column dwell; minimum 2.
- BLANK_CYCLES, 4, clk cycles col_blank stays high after every column change; minimum 1, must be < TICK_DIV.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- en  input  1  scan enable; when low the prescaler freezes.
- sel  input  2  command from shift FSM: 0 HOLD, 1 LOAD, 2 SHIFT, 3 reserved.
- scroll_en  input  1  when high, scroll_pos advances once per frame.
- active_col  output  NUM_COLS  one-hot active column, bit 0 = leftmost.
- col_idx  output  $clog2(NUM_COLS)  binary index of the set bit in active_col.
- col_blank  output  1  high while column drivers must be blanked.
- frame_start  output  1  one-cycle pulse when the scan returns to column 0.
- scroll_pos  output  $clog2(NUM_COLS)  frame scroll offset, 0..NUM_COLS-1.
- tick  output  1  one-cycle pulse marking each command-sample cycle.
- err  output  1  sticky flag for an illegal command or a broken one-hot state.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset (reset_n low at a clk edge) sets:
  - active_col = 1 and col_idx = 0.
  - scroll_pos = 0, prescaler = 0, blank counter = 0.
  - col_blank = 0, frame_start = 0, tick = 0, err = 0.
- Reset mid-scan takes effect at the next edge and overrides every other event.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en = 1 and holds its value while en = 0.
  - tick = 1 for exactly the cycle in which the count is TICK_DIV-1 and en = 1; the count then wraps to 0.
- sel is sampled only on tick cycles. Command effects are registered, so outputs change at the edge ending the tick cycle:
  - HOLD (0): no change.
  - LOAD (1): active_col = 1, col_idx = 0, frame_start pulses.
  - SHIFT (2): active_col rotates left by one and col_idx increments. From bit NUM_COLS-1 it wraps to bit 0, col_idx wraps to 0 and frame_start pulses.
  - Reserved (3): treated as HOLD and sets err.
- Any change to active_col loads the blank counter with BLANK_CYCLES:
  - col_blank = 1 while the counter is nonzero; the counter decrements every clk regardless of en.
  - A LOAD issued when active_col is already 1 still counts as a change: it blanks and pulses frame_start.
- scroll_pos:
  - Increments mod NUM_COLS in the same cycle frame_start is asserted, only if scroll_en = 1 in that cycle.
  - Wraps from NUM_COLS-1 to 0.
- err is also set if active_col is ever not one-hot; this is a checked invariant.
- err clears only on reset.
- sel or scroll_en changes between ticks have no effect.

Decomposition:
- Package panel_pkg holds:
  - NUM_COLS default constant.
  - Enum sel_t {SEL_HOLD = 2'd0, SEL_LOAD = 2'd1, SEL_SHIFT = 2'd2, SEL_RSVD = 2'd3}; the shift FSM reuses it.
  - Index width constant COL_IDX_W = $clog2(NUM_COLS).
- Sub-module tick_prescaler (parameter TICK_DIV; ports clk, reset_n, en, tick) generates the dwell tick.
- Blanking counter, column register, index counter and scroll counter stay inline.

Test Plan (TICK_DIV = 4, BLANK_CYCLES = 2, NUM_COLS = 24 unless stated):
- Reset: hold reset_n low with en = 1 and sel = 2 -> active_col = 24'h000001, col_idx = 0, no tick and all flags 0. Release -> first tick on the 4th cycle after release.
- Shift walk: sel = 2 held for 24 ticks -> active_col steps 0x1, 0x2, 0x4 … 0x800000, then back to 0x1. col_idx goes 0..23..0; frame_start pulses once at the wrap; col_blank is high 2 cycles after each step.
- Load mid-scan: shift to col_idx = 22, then sel = 1 on the next tick -> active_col = 0x1, frame_start pulse, scroll_pos unchanged with scroll_en = 0.
- Enable gating: drop en for 10 cycles mid-dwell -> no tick and active_col stable; the prescaler resumes from its held count.
- Scroll wrap: scroll_en = 1 with 24 consecutive LOADs -> scroll_pos goes 1..23, then 0.
- Error: sel = 3 at a tick -> active_col unchanged, err = 1 and stays 1 through later SHIFTs; reset -> err = 0.
